// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared encodings and MEM/WB register layout for the write-back stage
package wb_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } load_type_e;

    typedef enum logic [1:0] {
        WD_ALU = 2'd0,
        WD_MEM = 2'd1,
        WD_PC8 = 2'd2
    } wd_sel_e;

    // Raw codes are kept so undefined LoadType/WDSel values survive the register unchanged
    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        reg_write;
        logic [4:0]  a3;
        logic [1:0]  wd_sel;
        logic [2:0]  load_type;
    } mem_wb_t;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-side inputs and GRF write port of the write-back stage
interface wb_stage_if;
    logic        stall;
    logic        flush;
    logic        valid_MEM;
    logic [31:0] ALUResult_MEM;
    logic [31:0] ReadData_MEM;
    logic [31:0] PC_MEM;
    logic        RegWrite_MEM;
    logic [4:0]  A3_MEM;
    logic [1:0]  WDSel_MEM;
    logic [2:0]  LoadType_MEM;
    logic        RegWrite_WB;
    logic [4:0]  A3_WB;
    logic [31:0] WD_WB;
    logic [31:0] PC_WB;
    logic [31:0] retired;

    modport master (
        output stall, flush, valid_MEM, ALUResult_MEM, ReadData_MEM, PC_MEM,
               RegWrite_MEM, A3_MEM, WDSel_MEM, LoadType_MEM,
        input  RegWrite_WB, A3_WB, WD_WB, PC_WB, retired
    );

    modport slave (
        input  stall, flush, valid_MEM, ALUResult_MEM, ReadData_MEM, PC_MEM,
               RegWrite_MEM, A3_MEM, WDSel_MEM, LoadType_MEM,
        output RegWrite_WB, A3_WB, WD_WB, PC_WB, retired
    );
endinterface

// File: rtl/wb_stage_load_ext.sv
// rtl/wb_stage_load_ext.sv - byte/halfword lane select with sign or zero extension
module load_ext
    import wb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  load_type,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[7:0];
        case (addr)
            2'd0: byte_lane = word[7:0];
            2'd1: byte_lane = word[15:8];
            2'd2: byte_lane = word[23:16];
            2'd3: byte_lane = word[31:24];
            default: byte_lane = word[7:0];
        endcase
        // Halfword alignment faults are trapped upstream; addr[0] is ignored here
        half_lane = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = word;
        case (load_type)
            LD_B:    data = {{24{byte_lane[7]}}, byte_lane};
            LD_BU:   data = {24'd0, byte_lane};
            LD_H:    data = {{16{half_lane[15]}}, half_lane};
            LD_HU:   data = {16'd0, half_lane};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register, write-data select and retired-instruction counter
module wb_stage
    import wb_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic     clk,
    input  logic     reset,
    wb_stage_if.slave wb
);

    mem_wb_t     r_q;
    mem_wb_t     bubble;
    mem_wb_t     capture;
    logic [31:0] retired_cnt;
    logic [31:0] load_data;
    logic [31:0] wd;

    always_comb begin
        bubble           = '0;
        bubble.pc        = RESET_PC;
        capture          = '0;
        capture.valid     = wb.valid_MEM;
        capture.alu       = wb.ALUResult_MEM;
        capture.rdata     = wb.ReadData_MEM;
        capture.pc        = wb.PC_MEM;
        capture.reg_write = wb.RegWrite_MEM;
        capture.a3        = wb.A3_MEM;
        capture.wd_sel    = wb.WDSel_MEM;
        capture.load_type = wb.LoadType_MEM;
    end

    // Flush wins over stall so a squashed instruction never lingers in WB
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= bubble;
        end else if (wb.flush) begin
            r_q <= bubble;
        end else if (!wb.stall) begin
            r_q <= capture;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_cnt <= '0;
        end else if (!wb.flush && !wb.stall && wb.valid_MEM) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end

    load_ext u_load_ext (
        .word      (r_q.rdata),
        .addr      (r_q.alu[1:0]),
        .load_type (r_q.load_type),
        .data      (load_data)
    );

    always_comb begin
        wd = r_q.alu;
        case (r_q.wd_sel)
            WD_MEM:  wd = load_data;
            WD_PC8:  wd = r_q.pc + 32'd8;
            default: wd = r_q.alu;
        endcase
    end

    assign wb.RegWrite_WB = r_q.reg_write & r_q.valid & (r_q.a3 != 5'd0);
    assign wb.A3_WB       = r_q.a3;
    assign wb.WD_WB       = wd;
    assign wb.PC_WB       = r_q.pc;
    assign wb.retired     = retired_cnt;

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage pipelined CPU: holds the MEM/WB pipeline register, sign/zero-extends load data from data memory, selects the register-file write value, and drives the GRF write port. Its `WD_WB` output also feeds back to the memory stage as the store-data forwarding source. A retired-instruction counter supports performance checks in simulation.

## Interface
- `RESET_PC`, default 32'h0000_3000: value of `PC_WB` after reset and after a flush bubble.
- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `stall` in 1: hold the MEM/WB register contents.
- `flush` in 1: load a bubble into the MEM/WB register.
- `valid_MEM` in 1: instruction in MEM is real, not a bubble.
- `ALUResult_MEM` in 32: ALU result / memory address.
- `ReadData_MEM` in 32: word read from data memory.
- `PC_MEM` in 32: PC of the MEM instruction.
- `RegWrite_MEM` in 1: instruction writes the GRF.
- `A3_MEM` in 5: destination register.
- `WDSel_MEM` in 2: write-data source.
- `LoadType_MEM` in 3: load width/sign code.
- `RegWrite_WB` out 1: GRF write enable.
- `A3_WB` out 5: GRF write address.
- `WD_WB` out 32: GRF write data, also the forwarding value.
- `PC_WB` out 32: PC of the WB instruction.
- `retired` out 32: count of valid instructions that entered WB.

## Operation
- MEM/WB register fields: valid, ALUResult, ReadData, PC, RegWrite, A3, WDSel, LoadType.
- Each rising edge: if `flush`, load a bubble (valid=0, RegWrite=0, A3=0, WDSel=0, LoadType=0, data=0, PC=`RESET_PC`). Else if `stall`, hold. Else capture all `*_MEM` inputs.
- `flush` has priority over `stall` when both are high.
- `LoadType`: 0 word; 1 lb; 2 lbu; 3 lh; 4 lhu; codes 5-7 behave as word.
- Byte select uses registered ALUResult[1:0]. Halfword select uses ALUResult[1]; ALUResult[0] is ignored for halfwords, and alignment is not checked here.
- Byte lane n is bits [8n+7:8n]. Halfword 0 is [15:0]; halfword 1 is [31:16].
- `WDSel`: 0 selects ALUResult; 1 selects extended load data; 2 selects PC+8 (32-bit wrap); 3 is reserved and selects ALUResult.
- `RegWrite_WB` = registered RegWrite AND valid AND (A3 != 0). Writes to $0 are never issued.
- `WD_WB` is driven combinationally from register state, including when `RegWrite_WB`=0.
- `retired` increments by 1 on every edge that captures a valid instruction (not stall, not flush, `valid_MEM`=1). It wraps from 32'hFFFF_FFFF to 0. It holds during stall and flush.

## Timing
- Latency: 1 cycle from MEM inputs to WB outputs. `WD_WB` settles combinationally after the edge; there is no extra register.
- Reset (`reset`=0, asynchronous): `RegWrite_WB`=0, `A3_WB`=0, `WD_WB`=0, `PC_WB`=`RESET_PC`, `retired`=0. Outputs take these values immediately on assertion, with no clock needed.
- Reset deassertion is synchronised externally. The first capture happens on the first rising edge with `reset`=1.
- Reset mid-stall: the stall is discarded and the register holds a bubble.
- The GRF samples `RegWrite_WB`/`A3_WB`/`WD_WB` on the edge that ends the WB cycle. During stall the same write repeats, which is idempotent.

## Structure
- Shared package `wb_pkg`:
  - `LoadType` encodings (`LD_W`, `LD_B`, `LD_BU`, `LD_H`, `LD_HU`)
  - `WDSel` encodings (`WD_ALU`, `WD_MEM`, `WD_PC8`)
  - `RESET_PC` default
- One combinational sub-module, `load_ext`: (word, addr[1:0], LoadType) -> 32-bit extended data.
- The register, write-data mux and counter live in the top module.

## Test plan
- Reset: assert `reset`=0 mid-cycle -> outputs go to 0/`RESET_PC` immediately and `retired`=0; release and capture ALU write A3=5, ALU=32'h1234 -> next cycle `RegWrite_WB`=1, `WD_WB`=32'h1234, `retired`=1.
- Loads with ReadData=32'h80FF_7F01:
  - lb at addr[1:0]=3 -> 32'hFFFF_FF80
  - lbu at addr 2 -> 32'h0000_00FF
  - lh at addr 2 -> 32'hFFFF_80FF
  - lhu at addr 0 -> 32'h0000_7F01
  - word -> unchanged
- jal with PC_MEM=32'h0000_3010, WDSel=2, A3=31 -> `WD_WB`=32'h0000_3018. PC 32'hFFFF_FFFC -> 32'h0000_0004.
- Write to $0: RegWrite_MEM=1, A3=0 -> `RegWrite_WB`=0, and `retired` still increments.
- Stall for 3 cycles while inputs change -> WB outputs unchanged and `retired` constant. `stall`=1 with `flush`=1 -> bubble, `RegWrite_WB`=0.
- Counter wrap: force `retired` to 32'hFFFF_FFFF, capture one valid instruction -> 0. Capturing a bubble (`valid_MEM`=0) -> no increment.
